fp_min_reduce: RTL and testbench
================================

FP_MIN_REDUCE -- requirements
Module: fp_min_reduce

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, operand width; only 32 (single) or 64 (double) are legal.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream offers an operand.
REQ-005 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-006 SHALL have port in_data  input  BUS_WIDTH  IEEE-754 operand.
REQ-007 SHALL have port in_last  input  1  marks the final operand of a packet.
REQ-008 SHALL have port out_valid  output  1  packet minimum available.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port out_data  output  BUS_WIDTH  minimum of the packet.
REQ-011 SHALL have port out_count  output  16  operands in packet, saturating at 16'hFFFF.

Function
REQ-012 SHALL implement FSM states ACCUM and DONE; ACCUM: in_ready=1, out_valid=0; DONE: in_ready=0, out_valid=1.
REQ-013 SHALL treat a beat as accepted when in_valid & in_ready are high on a clock edge.
REQ-014 SHALL load the accumulator with in_data on the first accepted beat of a packet, otherwise with min(acc, in_data).
REQ-015 SHALL order non-NaN values totally: -inf < negatives < -0 < +0 < positives < +inf; signed zeros compare as -0 < +0.
REQ-016 SHALL classify NaN as exponent all-ones with nonzero mantissa; infinity as exponent all-ones with zero mantissa, either sign.
REQ-017 SHALL, when exactly one of acc/in_data is NaN, select the non-NaN operand unchanged.
REQ-018 SHALL, when both are NaN, produce canonical NaN (64'h7FF8000000000000 / 32'h7FC00000).
REQ-019 SHALL output canonical NaN, never the raw NaN payload, when every operand of a packet is NaN (including single-operand packets).
REQ-020 SHALL transition ACCUM->DONE on the edge accepting a beat with in_last=1; out_valid asserts the following cycle (latency 1 cycle after last beat).
REQ-021 SHALL hold out_data and out_count stable while out_valid=1 and out_ready=0.
REQ-022 SHALL transition DONE->ACCUM on the edge where out_valid & out_ready, and clear the first-beat flag and count.
REQ-023 SHALL not accept input in DONE, so a new packet never overlaps a pending result (one-cycle bubble between packets).
REQ-024 SHALL increment out_count per accepted beat and saturate at 16'hFFFF without wrap; comparison continues after saturation.
REQ-025 SHALL produce identical results for BUS_WIDTH 32 using 8-bit exponent/23-bit mantissa fields.

Reset
REQ-026 SHALL, on rising edge with rst_n=0, enter ACCUM, set first-beat flag, and clear out_data, out_count, and all flags to 0.
REQ-027 SHALL give rst_n priority over any handshake in the same cycle; a packet or pending result in flight is discarded.
REQ-028 SHALL drive in_ready=1 and out_valid=0 in the first cycle after reset deassertion.

Configuration
REQ-029 SHALL, with macro FP_MIN_REDUCE_INVALID_EN defined, add output out_invalid (1 bit) set when any operand of the packet is a signalling NaN (NaN with mantissa MSB=0), valid with out_valid, cleared on result handshake and reset.
REQ-030 SHALL, without FP_MIN_REDUCE_INVALID_EN, omit out_invalid entirely; all other behaviour identical.

Verification
REQ-031 SHALL cover: BUS_WIDTH=64, packet {3FF0000000000000, C000000000000000, 4008000000000000(last)} -> out_data=C000000000000000, out_count=3, out_valid one cycle after last beat.
REQ-032 SHALL cover: packet {0000000000000000, 8000000000000000(last)} -> out_data=8000000000000000 (-0).
REQ-033 SHALL cover: packet {7FF8000000000001, 3FF0000000000000, 7FF0000000000001(last)} -> out_data=3FF0000000000000; with FP_MIN_REDUCE_INVALID_EN out_invalid=1.
REQ-034 SHALL cover: single-beat packet {7FF4000000000000(last)} -> out_data=7FF8000000000000, out_count=1.
REQ-035 SHALL cover: out_ready held low 5 cycles after result -> out_data stable, in_ready=0 throughout; result handshake then in_ready=1 next cycle.
REQ-036 SHALL cover: rst_n=0 asserted mid-packet after 2 beats -> next cycle out_valid=0, out_count=0; next packet {BFF0000000000000(last)} -> out_data=BFF0000000000000, out_count=1.

Source files
------------

// File: rtl/fp_min_reduce.sv
// Streaming IEEE-754 minimum reducer: folds each in_last-terminated packet into one minimum plus a beat count.
// Optional FP_MIN_REDUCE_INVALID_EN adds out_invalid, flagging any signalling NaN seen in the packet.
module fp_min_reduce #(
  parameter int BUS_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [15:0]          out_count,
`ifdef FP_MIN_REDUCE_INVALID_EN
  output logic                 out_invalid,
`endif
  output logic [0:0]           dbg_state
);

  localparam int EXP_W = (BUS_WIDTH == 32) ? 8 : 11;
  localparam int MAN_W = BUS_WIDTH - 1 - EXP_W;
  localparam logic [BUS_WIDTH-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [BUS_WIDTH-1:0] SIGN_BIT  = {1'b1, {(BUS_WIDTH-1){1'b0}}};

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DONE  = 1'b1;

  if (BUS_WIDTH != 32 && BUS_WIDTH != 64) begin : g_bad_width
    $error("fp_min_reduce: BUS_WIDTH must be 32 or 64");
  end

  // Handshake: a beat moves on a rising edge where valid and ready are both high;
  // the producer holds valid/data until then, and ready never depends on valid.

  logic [0:0]           state;
  logic                 first;
  logic [BUS_WIDTH-1:0] acc;
  logic [15:0]          count;
  logic                 invalid;

  function automatic logic is_nan(input logic [BUS_WIDTH-1:0] x);
    return (&x[BUS_WIDTH-2 -: EXP_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_snan(input logic [BUS_WIDTH-1:0] x);
    return is_nan(x) && !x[MAN_W-1];
  endfunction

  // Map sign-magnitude onto an unsigned key whose order matches -inf < ... < -0 < +0 < ... < +inf.
  function automatic logic [BUS_WIDTH-1:0] order_key(input logic [BUS_WIDTH-1:0] x);
    return x[BUS_WIDTH-1] ? ~x : (x ^ SIGN_BIT);
  endfunction

  logic                 acc_nan;
  logic                 din_nan;
  logic [BUS_WIDTH-1:0] min_val;
  logic [BUS_WIDTH-1:0] next_acc;
  logic [15:0]          next_count;

  always_comb begin
    acc_nan = is_nan(acc);
    din_nan = is_nan(in_data);
    min_val = acc;
    if (acc_nan && din_nan)
      min_val = CANON_NAN;
    else if (acc_nan)
      min_val = in_data;
    else if (din_nan)
      min_val = acc;
    else if (order_key(in_data) < order_key(acc))
      min_val = in_data;

    // A packet's first NaN is canonicalised on load, so an all-NaN packet never leaks a payload.
    if (first)
      next_acc = din_nan ? CANON_NAN : in_data;
    else
      next_acc = min_val;

    if (first)
      next_count = 16'd1;
    else if (count == 16'hFFFF)
      next_count = count;
    else
      next_count = count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ACCUM;
      first   <= 1'b1;
      acc     <= '0;
      count   <= '0;
      invalid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc     <= next_acc;
            count   <= next_count;
            invalid <= (invalid && !first) || is_snan(in_data);
            first   <= 1'b0;
            if (in_last)
              state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state   <= ACCUM;
            first   <= 1'b1;
            count   <= '0;
            invalid <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_data  = acc;
  assign out_count = count;
  assign dbg_state = state;
`ifdef FP_MIN_REDUCE_INVALID_EN
  assign out_invalid = invalid;
`endif

endmodule

// File: tb/tb_fp_min_reduce.sv
// Directed self-checking bench for fp_min_reduce (BUS_WIDTH=64); each scenario task checks its own results.
module tb_fp_min_reduce;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [15:0] out_count;
  logic [0:0]  dbg_state;
`ifdef FP_MIN_REDUCE_INVALID_EN
  logic        out_invalid;
`endif

  int checks = 0;
  int errors = 0;

  fp_min_reduce #(.BUS_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
`ifdef FP_MIN_REDUCE_INVALID_EN
    .out_invalid(out_invalid),
`endif
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: inputs change 1 time unit after the rising edge; outputs are read at that point too.
  task automatic drive_beat(input logic [63:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 64'h4000000000000000; in_last = 1'b1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_count !== 16'd0) begin errors++; $display("FAIL reset_count got %h exp 0000", out_count); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b exp 0", dbg_state); end
  endtask

  task automatic test_basic;
    drive_beat(64'h3FF0000000000000, 1'b0);
    drive_beat(64'hC000000000000000, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
    drive_beat(64'h4008000000000000, 1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency got %b exp 1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready got %b exp 0", in_ready); end
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL basic_state got %b exp 1", dbg_state); end
    checks++; if (out_data !== 64'hC000000000000000) begin errors++; $display("FAIL basic_data got %h exp c000000000000000", out_data); end
    checks++; if (out_count !== 16'd3) begin errors++; $display("FAIL basic_count got %0d exp 3", out_count); end
    take_result();
  endtask

  task automatic test_signed_zero;
    drive_beat(64'h0000000000000000, 1'b0);
    drive_beat(64'h8000000000000000, 1'b1);
    checks++; if (out_data !== 64'h8000000000000000) begin errors++; $display("FAIL zero_pos_neg got %h exp 8000000000000000", out_data); end
    take_result();
    drive_beat(64'h8000000000000000, 1'b0);
    drive_beat(64'h0000000000000000, 1'b1);
    checks++; if (out_data !== 64'h8000000000000000) begin errors++; $display("FAIL zero_neg_pos got %h exp 8000000000000000", out_data); end
    checks++; if (out_count !== 16'd2) begin errors++; $display("FAIL zero_count got %0d exp 2", out_count); end
    take_result();
  endtask

  task automatic test_nan_mix;
    drive_beat(64'h7FF8000000000001, 1'b0);
    drive_beat(64'h3FF0000000000000, 1'b0);
    drive_beat(64'h7FF0000000000001, 1'b1);
    checks++; if (out_data !== 64'h3FF0000000000000) begin errors++; $display("FAIL nan_mix_data got %h exp 3ff0000000000000", out_data); end
`ifdef FP_MIN_REDUCE_INVALID_EN
    checks++; if (out_invalid !== 1'b1) begin errors++; $display("FAIL nan_mix_invalid got %b exp 1", out_invalid); end
`endif
    take_result();
  endtask

  task automatic test_nan_only;
    drive_beat(64'h7FF4000000000000, 1'b1);
    checks++; if (out_data !== 64'h7FF8000000000000) begin errors++; $display("FAIL snan_single_data got %h exp 7ff8000000000000", out_data); end
    checks++; if (out_count !== 16'd1) begin errors++; $display("FAIL snan_single_count got %0d exp 1", out_count); end
    take_result();
    drive_beat(64'h7FF8000000000001, 1'b0);
    drive_beat(64'hFFF8000000000005, 1'b1);
    checks++; if (out_data !== 64'h7FF8000000000000) begin errors++; $display("FAIL qnan_pair_data got %h exp 7ff8000000000000", out_data); end
`ifdef FP_MIN_REDUCE_INVALID_EN
    checks++; if (out_invalid !== 1'b0) begin errors++; $display("FAIL qnan_pair_invalid got %b exp 0", out_invalid); end
`endif
    take_result();
  endtask

  task automatic test_infinities;
    drive_beat(64'h7FF0000000000000, 1'b0);
    drive_beat(64'hFFF0000000000000, 1'b0);
    drive_beat(64'hC000000000000000, 1'b1);
    checks++; if (out_data !== 64'hFFF0000000000000) begin errors++; $display("FAIL inf_neg_data got %h exp fff0000000000000", out_data); end
    take_result();
    drive_beat(64'h7FF0000000000000, 1'b0);
    drive_beat(64'hBFF0000000000000, 1'b0);
    drive_beat(64'hC008000000000000, 1'b1);
    checks++; if (out_data !== 64'hC008000000000000) begin errors++; $display("FAIL neg_order_data got %h exp c008000000000000", out_data); end
    take_result();
  endtask

  task automatic test_backpressure;
    drive_beat(64'h4000000000000000, 1'b0);
    drive_beat(64'h3FF0000000000000, 1'b1);
    in_valid = 1'b1; in_data = 64'hFFF0000000000000; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++; if (out_data !== 64'h3FF0000000000000) begin errors++; $display("FAIL hold_data cyc %0d got %h exp 3ff0000000000000", i, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc %0d got %b exp 0", i, in_ready); end
      checks++; if (out_count !== 16'd2) begin errors++; $display("FAIL hold_count cyc %0d got %0d exp 2", i, out_count); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    take_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got %b exp 0", out_valid); end
    checks++; if (out_count !== 16'd0) begin errors++; $display("FAIL release_count got %0d exp 0", out_count); end
  endtask

  task automatic test_mid_reset;
    drive_beat(64'hC010000000000000, 1'b0);
    drive_beat(64'hC020000000000000, 1'b0);
    rst_n = 1'b0;
    in_valid = 1'b1; in_data = 64'hC030000000000000; in_last = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
    checks++; if (out_count !== 16'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", out_count); end
    drive_beat(64'hBFF0000000000000, 1'b1);
    checks++; if (out_data !== 64'hBFF0000000000000) begin errors++; $display("FAIL midrst_data got %h exp bff0000000000000", out_data); end
    checks++; if (out_count !== 16'd1) begin errors++; $display("FAIL midrst_next_count got %0d exp 1", out_count); end
    take_result();
  endtask

  task automatic test_saturation;
    in_valid = 1'b1; in_last = 1'b0; in_data = 64'h3FF0000000000000;
    repeat (65536) @(posedge clk);
    #1;
    checks++; if (out_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count_mid got %h exp ffff", out_count); end
    in_data = 64'h8000000000000000; in_last = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (out_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count_final got %h exp ffff", out_count); end
    checks++; if (out_data !== 64'h8000000000000000) begin errors++; $display("FAIL sat_data got %h exp 8000000000000000", out_data); end
    take_result();
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    test_reset();
    test_basic();
    test_signed_zero();
    test_nan_mix();
    test_nan_only();
    test_infinities();
    test_backpressure();
    test_mid_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
